// File: rtl/ps2_keyboard_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keyboard_sequencer_if
// Description : Bundles the PS2_Controller command/receive signals, the LED
//               request handshake and the decoded key-event outputs of the
//               keyboard sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_keyboard_sequencer_if;
  // PS2_Controller side
  logic [7:0] ps2_received_data;
  logic       ps2_received_data_en;
  logic       ps2_command_was_sent;
  logic       ps2_error_timed_out;
  logic [7:0] ps2_the_command;
  logic       ps2_send_command;
  // Game-logic side
  logic       led_req;
  logic [2:0] led_value;
  logic       led_busy;
  logic       kbd_ready;
  logic       kbd_error;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_released;

  // The sequencer itself
  modport master (
    input  ps2_received_data, ps2_received_data_en,
    input  ps2_command_was_sent, ps2_error_timed_out,
    output ps2_the_command, ps2_send_command,
    input  led_req, led_value,
    output led_busy, kbd_ready, kbd_error,
    output key_valid, key_code, key_extended, key_released
  );

  // Everything surrounding the sequencer (PS2_Controller plus game FSM)
  modport slave (
    output ps2_received_data, ps2_received_data_en,
    output ps2_command_was_sent, ps2_error_timed_out,
    input  ps2_the_command, ps2_send_command,
    output led_req, led_value,
    input  led_busy, kbd_ready, kbd_error,
    input  key_valid, key_code, key_extended, key_released
  );
endinterface
`default_nettype wire

// File: rtl/ps2_keyboard_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keyboard_sequencer
// Description : Owns the PS2_Controller command port. Resets the keyboard
//               (0xFF / 0xFA / 0xAA), services LED updates (0xED + value)
//               with ACK checking, resend and timeouts, and decodes scan-code
//               set 2 byte streams into single-cycle key events.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keyboard_sequencer #(
  parameter int ACK_TIMEOUT = 1_000_000,
  parameter int BAT_TIMEOUT = 50_000_000,
  parameter int RETRY_MAX   = 3,
  parameter int CNT_W       = 26
) (
  input  wire                       CLOCK_50,
  input  wire                       reset,
  ps2_keyboard_sequencer_if.master  bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [3:0] c_ST_INIT_SEND = 4'd0;
  localparam logic [3:0] c_ST_INIT_ACK  = 4'd1;
  localparam logic [3:0] c_ST_INIT_BAT  = 4'd2;
  localparam logic [3:0] c_ST_IDLE      = 4'd3;
  localparam logic [3:0] c_ST_LED_CMD   = 4'd4;
  localparam logic [3:0] c_ST_LED_ACK1  = 4'd5;
  localparam logic [3:0] c_ST_LED_VAL   = 4'd6;
  localparam logic [3:0] c_ST_LED_ACK2  = 4'd7;
  localparam logic [3:0] c_ST_ERROR     = 4'd8;

  localparam int                     c_RETRY_W   = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [c_RETRY_W-1:0]   c_RETRY_MAX = c_RETRY_W'(RETRY_MAX);
  localparam logic [CNT_W-1:0]       c_ACK_TO    = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0]       c_BAT_TO    = CNT_W'(BAT_TIMEOUT);

  localparam logic [7:0] c_CMD_RESET = 8'hFF;
  localparam logic [7:0] c_CMD_LED   = 8'hED;
  localparam logic [7:0] c_RSP_ACK   = 8'hFA;
  localparam logic [7:0] c_RSP_RSND  = 8'hFE;
  localparam logic [7:0] c_RSP_BAT   = 8'hAA;
  localparam logic [7:0] c_RSP_BATF  = 8'hFC;
  localparam logic [7:0] c_SC_EXT    = 8'hE0;
  localparam logic [7:0] c_SC_BRK    = 8'hF0;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [3:0]           r_state;
  logic [3:0]           w_state_next;
  // r_gap forces send_command low for one cycle: after reset and after a
  // controller timeout, so PS2_Controller can leave END_TRANSFER.
  logic                 r_gap;
  logic                 w_gap_next;
  logic [c_RETRY_W-1:0] r_retry;
  logic                 w_retry_inc;
  logic                 w_retry_clr;
  logic [CNT_W-1:0]     r_timer;
  logic [2:0]           r_led_val;
  logic                 w_led_accept;

  logic                 r_ext;
  logic                 r_brk;
  logic                 r_key_valid;
  logic [7:0]           r_key_code;
  logic                 r_key_ext;
  logic                 r_key_rel;

  logic [7:0]           w_cmd;
  logic                 w_send;
  logic                 w_busy;
  logic                 w_ready;
  logic                 w_error;

  // --------------------------------------------------------------------------
  // Byte classification and routing
  // --------------------------------------------------------------------------
  wire  w_rx     = bus.ps2_received_data_en;
  wire  w_rx_fa  = w_rx && (bus.ps2_received_data == c_RSP_ACK);
  wire  w_rx_fe  = w_rx && (bus.ps2_received_data == c_RSP_RSND);
  wire  w_rx_aa  = w_rx && (bus.ps2_received_data == c_RSP_BAT);
  wire  w_rx_fc  = w_rx && (bus.ps2_received_data == c_RSP_BATF);

  wire  w_in_ack = (r_state == c_ST_INIT_ACK) || (r_state == c_ST_LED_ACK1) ||
                   (r_state == c_ST_LED_ACK2);
  wire  w_in_bat = (r_state == c_ST_INIT_BAT);
  wire  w_in_send = (r_state == c_ST_INIT_SEND) || (r_state == c_ST_LED_CMD) ||
                    (r_state == c_ST_LED_VAL);

  wire  w_consumed   = (w_in_ack && (w_rx_fa || w_rx_fe)) ||
                       (w_in_bat && (w_rx_aa || w_rx_fc));
  wire  w_dec_strobe = w_rx && !w_consumed;

  // Outcome of the current attempt in the send / ACK states
  wire  w_send_ok    = !r_gap && bus.ps2_command_was_sent;
  wire  w_send_fail  = !r_gap && !bus.ps2_command_was_sent && bus.ps2_error_timed_out;
  wire  w_ack_fail   = !w_rx_fa && (w_rx_fe || (r_timer == c_ACK_TO));
  wire  w_exhausted  = (r_retry == c_RETRY_MAX);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // State and gap flag; gap comes up set so send_command is low during reset
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_INIT_SEND;
      r_gap   <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_gap   <= w_gap_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  // Sequencing, retry decisions and LED request acceptance
  always_comb begin
    w_state_next = r_state;
    w_gap_next   = 1'b0;
    w_retry_inc  = 1'b0;
    w_retry_clr  = 1'b0;
    w_led_accept = 1'b0;
    case (r_state)
      c_ST_INIT_SEND: begin
        if (w_send_ok) begin
          w_state_next = c_ST_INIT_ACK;
        end else if (w_send_fail) begin
          if (w_exhausted) begin
            w_state_next = c_ST_ERROR;
          end else begin
            w_retry_inc = 1'b1;
            w_gap_next  = 1'b1;
          end
        end
      end
      c_ST_INIT_ACK: begin
        if (w_rx_fa) begin
          w_state_next = c_ST_INIT_BAT;
          w_retry_clr  = 1'b1;
        end else if (w_ack_fail) begin
          if (w_exhausted) begin
            w_state_next = c_ST_ERROR;
          end else begin
            w_retry_inc  = 1'b1;
            w_state_next = c_ST_INIT_SEND;
            w_gap_next   = 1'b1;
          end
        end
      end
      c_ST_INIT_BAT: begin
        if (w_rx_aa) begin
          w_state_next = c_ST_IDLE;
          w_retry_clr  = 1'b1;
        end else if (w_rx_fc || (r_timer == c_BAT_TO)) begin
          w_state_next = c_ST_ERROR;
        end
      end
      c_ST_IDLE: begin
        if (bus.led_req) begin
          w_state_next = c_ST_LED_CMD;
          w_led_accept = 1'b1;
        end
      end
      c_ST_LED_CMD: begin
        if (w_send_ok) begin
          w_state_next = c_ST_LED_ACK1;
        end else if (w_send_fail) begin
          if (w_exhausted) begin
            w_state_next = c_ST_ERROR;
          end else begin
            w_retry_inc = 1'b1;
            w_gap_next  = 1'b1;
          end
        end
      end
      c_ST_LED_ACK1: begin
        if (w_rx_fa) begin
          w_state_next = c_ST_LED_VAL;
          w_retry_clr  = 1'b1;
        end else if (w_ack_fail) begin
          if (w_exhausted) begin
            w_state_next = c_ST_ERROR;
          end else begin
            w_retry_inc  = 1'b1;
            w_state_next = c_ST_LED_CMD;
            w_gap_next   = 1'b1;
          end
        end
      end
      c_ST_LED_VAL: begin
        if (w_send_ok) begin
          w_state_next = c_ST_LED_ACK2;
        end else if (w_send_fail) begin
          if (w_exhausted) begin
            w_state_next = c_ST_ERROR;
          end else begin
            w_retry_inc = 1'b1;
            w_gap_next  = 1'b1;
          end
        end
      end
      c_ST_LED_ACK2: begin
        if (w_rx_fa) begin
          w_state_next = c_ST_IDLE;
          w_retry_clr  = 1'b1;
        end else if (w_ack_fail) begin
          if (w_exhausted) begin
            w_state_next = c_ST_ERROR;
          end else begin
            w_retry_inc  = 1'b1;
            w_state_next = c_ST_LED_VAL;
            w_gap_next   = 1'b1;
          end
        end
      end
      c_ST_ERROR: begin
        w_state_next = c_ST_ERROR;
      end
      default: begin
        w_state_next = c_ST_INIT_SEND;
        w_gap_next   = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  // Command byte and status flags decoded from the current state
  always_comb begin
    w_cmd   = 8'h00;
    w_send  = 1'b0;
    w_busy  = 1'b0;
    w_ready = 1'b0;
    w_error = 1'b0;
    case (r_state)
      c_ST_INIT_SEND: begin
        w_send = !r_gap;
        w_cmd  = r_gap ? 8'h00 : c_CMD_RESET;
      end
      c_ST_IDLE: begin
        w_ready = 1'b1;
      end
      c_ST_LED_CMD: begin
        w_send  = !r_gap;
        w_cmd   = r_gap ? 8'h00 : c_CMD_LED;
        w_busy  = 1'b1;
        w_ready = 1'b1;
      end
      c_ST_LED_ACK1, c_ST_LED_ACK2: begin
        w_busy  = 1'b1;
        w_ready = 1'b1;
      end
      c_ST_LED_VAL: begin
        w_send  = !r_gap;
        w_cmd   = r_gap ? 8'h00 : {5'b00000, r_led_val};
        w_busy  = 1'b1;
        w_ready = 1'b1;
      end
      c_ST_ERROR: begin
        w_error = 1'b1;
      end
      default: begin
        w_cmd = 8'h00;
      end
    endcase
  end

  assign bus.ps2_the_command  = w_cmd;
  assign bus.ps2_send_command = w_send;
  assign bus.led_busy         = w_busy;
  assign bus.kbd_ready        = w_ready;
  assign bus.kbd_error        = w_error;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  // Per-byte retry count, response timer and latched LED value
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_retry   <= '0;
      r_timer   <= '0;
      r_led_val <= 3'b000;
    end else begin
      if (w_retry_clr) begin
        r_retry <= '0;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + 1'b1;
      end
      if (w_state_next != r_state) begin
        r_timer <= '0;
      end else if (w_in_ack || w_in_bat) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_led_accept) begin
        r_led_val <= bus.led_value;
      end
    end
  end

  // Scan-code set 2 decoder: prefix flags and one-cycle key event
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_key_valid <= 1'b0;
      r_key_code  <= 8'h00;
      r_key_ext   <= 1'b0;
      r_key_rel   <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_dec_strobe) begin
        case (bus.ps2_received_data)
          c_SC_EXT: r_ext <= 1'b1;
          c_SC_BRK: r_brk <= 1'b1;
          8'h00, 8'hFF: begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
          end
          default: begin
            r_key_valid <= 1'b1;
            r_key_code  <= bus.ps2_received_data;
            r_key_ext   <= r_ext;
            r_key_rel   <= r_brk;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.key_valid    = r_key_valid;
  assign bus.key_code     = r_key_code;
  assign bus.key_extended = r_key_ext;
  assign bus.key_released = r_key_rel;

  // Send states are only ever left through the next-state logic above
  wire w_unused_send = w_in_send;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_keyboard_sequencer
// Description : Directed self-checking bench for ps2_keyboard_sequencer with
//               command and key-event scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_sequencer;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_keyboard_sequencer_if bus();

  ps2_keyboard_sequencer #(
    .ACK_TIMEOUT (100),
    .BAT_TIMEOUT (400),
    .RETRY_MAX   (3),
    .CNT_W       (26)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } key_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_sends = 0;
  logic       prev_send = 1'b0;
  logic [7:0] q_cmd[$];
  key_t       q_key[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Command scoreboard: every rising send_command must match the next queued byte
  always @(negedge CLOCK_50) begin
    if (bus.ps2_send_command === 1'b1 && prev_send === 1'b0) begin
      n_sends++;
      check("cmd_expected", 32'(q_cmd.size() > 0), 32'd1);
      if (q_cmd.size() > 0) check("cmd_byte", 32'(bus.ps2_the_command), 32'(q_cmd.pop_front()));
    end
    prev_send = bus.ps2_send_command;
  end

  // Key-event scoreboard
  always @(negedge CLOCK_50) begin
    if (!reset && bus.key_valid === 1'b1) begin
      check("key_expected", 32'(q_key.size() > 0), 32'd1);
      if (q_key.size() > 0) begin
        key_t e;
        e = q_key.pop_front();
        check("key_code", 32'(bus.key_code), 32'(e.code));
        check("key_ext",  32'(bus.key_extended), 32'(e.ext));
        check("key_rel",  32'(bus.key_released), 32'(e.rel));
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed still running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic feed(input logic [7:0] b);
    bus.ps2_received_data    = b;
    bus.ps2_received_data_en = 1'b1;
    @(negedge CLOCK_50);
    bus.ps2_received_data_en = 1'b0;
  endtask

  // Wait for a send, then answer with command_was_sent or a controller timeout
  task automatic do_send(input bit use_timeout);
    int k;
    k = 0;
    while (bus.ps2_send_command !== 1'b1 && k < 300) begin
      @(negedge CLOCK_50);
      k++;
    end
    check("send_seen", 32'(bus.ps2_send_command), 32'd1);
    if (use_timeout) bus.ps2_error_timed_out = 1'b1;
    else             bus.ps2_command_was_sent = 1'b1;
    @(negedge CLOCK_50);
    k = 0;
    while (bus.ps2_send_command !== 1'b0 && k < 50) begin
      @(negedge CLOCK_50);
      k++;
    end
    check("send_dropped", 32'(bus.ps2_send_command), 32'd0);
    bus.ps2_command_was_sent = 1'b0;
    bus.ps2_error_timed_out  = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic pulse_led(input logic [2:0] v);
    bus.led_value = v;
    bus.led_req   = 1'b1;
    @(negedge CLOCK_50);
    bus.led_req   = 1'b0;
  endtask

  initial begin
    int k;
    int s0;
    bus.ps2_received_data    = 8'h00;
    bus.ps2_received_data_en = 1'b0;
    bus.ps2_command_was_sent = 1'b0;
    bus.ps2_error_timed_out  = 1'b0;
    bus.led_req              = 1'b0;
    bus.led_value            = 3'b000;
    repeat (3) @(negedge CLOCK_50);

    // Reset values
    check("rst_send",  32'(bus.ps2_send_command), 32'd0);
    check("rst_cmd",   32'(bus.ps2_the_command), 32'h00);
    check("rst_busy",  32'(bus.led_busy), 32'd0);
    check("rst_ready", 32'(bus.kbd_ready), 32'd0);
    check("rst_error", 32'(bus.kbd_error), 32'd0);
    check("rst_kv",    32'(bus.key_valid), 32'd0);
    check("rst_kcode", 32'(bus.key_code), 32'h00);

    // Normal init
    q_cmd.push_back(8'hFF);
    reset = 1'b0;
    do_send(1'b0);
    feed(8'hFA);
    check("init_not_ready_before_bat", 32'(bus.kbd_ready), 32'd0);
    feed(8'hAA);
    @(negedge CLOCK_50);
    check("init_ready", 32'(bus.kbd_ready), 32'd1);
    check("init_error", 32'(bus.kbd_error), 32'd0);
    check("init_sends", 32'(n_sends), 32'd1);

    // Key decode, including an overrun byte clearing a pending prefix
    q_key.push_back('{8'h1C, 1'b0, 1'b0});
    q_key.push_back('{8'h1C, 1'b0, 1'b1});
    q_key.push_back('{8'h75, 1'b1, 1'b1});
    q_key.push_back('{8'h6B, 1'b0, 1'b0});
    feed(8'h1C);
    feed(8'hF0); feed(8'h1C);
    feed(8'hE0); feed(8'hF0); feed(8'h75);
    feed(8'hE0); feed(8'hFF); feed(8'h6B);
    repeat (3) @(negedge CLOCK_50);
    check("keys_drained", 32'(q_key.size()), 32'd0);

    // LED update 3'b101; a second request while busy must be dropped
    q_cmd.push_back(8'hED);
    q_cmd.push_back(8'h05);
    pulse_led(3'b101);
    check("led_busy_accept", 32'(bus.led_busy), 32'd1);
    pulse_led(3'b010);
    do_send(1'b0);
    feed(8'hFA);
    check("led_busy_mid", 32'(bus.led_busy), 32'd1);
    do_send(1'b0);
    feed(8'hFA);
    check("led_busy_done", 32'(bus.led_busy), 32'd0);
    check("led_ready", 32'(bus.kbd_ready), 32'd1);

    // Resend: controller timeout, 0xFE twice, then ACK on the last allowed try
    s0 = n_sends;
    repeat (4) q_cmd.push_back(8'hED);
    q_cmd.push_back(8'h05);
    pulse_led(3'b101);
    do_send(1'b1);
    do_send(1'b0); feed(8'hFE);
    do_send(1'b0); feed(8'hFE);
    do_send(1'b0); feed(8'hFA);
    do_send(1'b0); feed(8'hFA);
    check("resend_count", 32'(n_sends - s0), 32'd5);
    check("resend_error", 32'(bus.kbd_error), 32'd0);
    check("resend_busy",  32'(bus.led_busy), 32'd0);

    // Reset while the LED value byte is being sent
    q_cmd.push_back(8'hED);
    q_cmd.push_back(8'h03);
    pulse_led(3'b011);
    do_send(1'b0);
    feed(8'hFA);
    k = 0;
    while (bus.ps2_send_command !== 1'b1 && k < 20) begin
      @(negedge CLOCK_50);
      k++;
    end
    check("ledval_sending", 32'(bus.ps2_send_command), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("midrst_send",  32'(bus.ps2_send_command), 32'd0);
    check("midrst_busy",  32'(bus.led_busy), 32'd0);
    check("midrst_ready", 32'(bus.kbd_ready), 32'd0);
    check("midrst_kcode", 32'(bus.key_code), 32'h00);
    repeat (4) q_cmd.push_back(8'hFF);
    @(negedge CLOCK_50);
    reset = 1'b0;

    // Failure: 0xFF never acknowledged -> four sends then ERROR
    s0 = n_sends;
    repeat (4) do_send(1'b0);
    k = 0;
    while (bus.kbd_error !== 1'b1 && k < 300) begin
      @(negedge CLOCK_50);
      k++;
    end
    check("fail_error", 32'(bus.kbd_error), 32'd1);
    check("fail_ready", 32'(bus.kbd_ready), 32'd0);
    check("fail_sends", 32'(n_sends - s0), 32'd4);
    pulse_led(3'b111);
    repeat (300) @(negedge CLOCK_50);
    check("fail_no_more_sends", 32'(n_sends - s0), 32'd4);
    check("fail_busy", 32'(bus.led_busy), 32'd0);

    // Decoder keeps running in ERROR
    q_key.push_back('{8'h1C, 1'b0, 1'b1});
    feed(8'hF0); feed(8'h1C);
    repeat (3) @(negedge CLOCK_50);
    check("err_keys_drained", 32'(q_key.size()), 32'd0);
    check("cmds_drained", 32'(q_cmd.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_keyboard_sequencer.md
Name: ps2_keyboard_sequencer

Overview:
- Controller that sits above PS2_Controller (instantiated with INITIALIZE_MOUSE=0) and owns its command port.
- After reset it initialises the keyboard: sends 0xFF, waits for ACK 0xFA, then waits for BAT-pass 0xAA.
- Services LED-update requests from game logic using the 0xED + value sequence, with ACK checking, resend and timeouts.
- Decodes received scan-code set 2 byte streams (E0 and F0 prefixes) into single-cycle key events for the blackjack game FSM.

Parameters:
- ACK_TIMEOUT, 1_000_000, CLOCK_50 cycles to wait for 0xFA/0xFE after a command was sent (20 ms).
- BAT_TIMEOUT, 50_000_000, cycles to wait for 0xAA after the reset ACK (1 s).
- RETRY_MAX, 3, resends allowed per byte on 0xFE or on a PS2_Controller timeout.
- CNT_W, 26, width of the timeout counter; must hold max(ACK_TIMEOUT, BAT_TIMEOUT).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- ps2_received_data  in  8  byte from PS2_Controller received_data
- ps2_received_data_en  in  1  one-cycle strobe, byte valid
- ps2_command_was_sent  in  1  from PS2_Controller command_was_sent
- ps2_error_timed_out  in  1  from PS2_Controller error_communication_timed_out
- ps2_the_command  out  8  to PS2_Controller the_command
- ps2_send_command  out  1  to PS2_Controller send_command
- led_req  in  1  one-cycle request to update the LEDs
- led_value  in  3  {caps, num, scroll}; sampled when led_req is accepted
- led_busy  out  1  high while an LED sequence is in progress; led_req is ignored while high
- kbd_ready  out  1  high in IDLE and the LED states once init has succeeded
- kbd_error  out  1  sticky; set on retry exhaustion, BAT timeout or 0xFC; cleared only by reset
- key_valid  out  1  one-cycle key event strobe
- key_code  out  8  final scan-code byte; held until the next event
- key_extended  out  1  event was preceded by 0xE0
- key_released  out  1  event was preceded by 0xF0

Behaviour:
- Reset is asynchronous, active-high; CLOCK_50 is the clock.
- Reset values: ps2_the_command=0x00, ps2_send_command=0, led_busy=0, kbd_ready=0, kbd_error=0, key_valid=0, key_code=0x00, key_extended=0, key_released=0. State=INIT_SEND, retry=0, timer=0, prefix flags=0.
- Send handshake (used by every *_SEND state):
  - Drive ps2_the_command and hold ps2_send_command=1 until ps2_command_was_sent or ps2_error_timed_out is seen.
  - Then drive ps2_send_command=0 for at least 1 cycle before the next send; PS2_Controller only leaves END_TRANSFER on send_command=0.
  - ps2_error_timed_out counts as a failed attempt, same as 0xFE.
- States:
  - INIT_SEND: send 0xFF. Go to INIT_ACK.
  - INIT_ACK: clear the timer on entry. 0xFA -> INIT_BAT. 0xFE, or timer=ACK_TIMEOUT -> retry++, back to INIT_SEND.
  - INIT_BAT: 0xAA -> IDLE and set kbd_ready. 0xFC, or timer=BAT_TIMEOUT -> ERROR.
  - IDLE: led_req -> latch led_value, set led_busy, go to LED_CMD.
  - LED_CMD: send 0xED. Go to LED_ACK1.
  - LED_ACK1: same rules as INIT_ACK. 0xFA -> LED_VAL; failure retries LED_CMD.
  - LED_VAL: send {5'b0, latched value}. Go to LED_ACK2.
  - LED_ACK2: 0xFA -> clear led_busy, go to IDLE; failure retries LED_VAL.
  - ERROR: terminal. kbd_error=1, kbd_ready=0, led_busy=0, no sends. The decoder stays active.
- Retry counter: cleared whenever a byte is ACKed and on entry to IDLE. An attempt made with retry=RETRY_MAX fails -> ERROR. So at most RETRY_MAX+1 transmissions per byte.
- Byte routing:
  - In the *_ACK states, 0xFA and 0xFE are consumed.
  - In INIT_BAT, 0xAA and 0xFC are consumed.
  - Every other strobed byte, in every state, goes to the decoder.
- Decoder:
  - 0xE0 sets ext. 0xF0 sets brk.
  - 0x00 and 0xFF (overrun) clear both flags and emit nothing.
  - Any other byte: on the next cycle key_valid=1, key_code=byte, key_extended=ext, key_released=brk; then both flags clear.
  - Latency: 1 cycle from the strobe to key_valid.
- Simultaneous events:
  - led_req in the same cycle as the IDLE->LED transition decision: the request is accepted.
  - led_req while led_busy=1 or !kbd_ready: dropped, no queueing.
  - A byte strobe coinciding with a state change is evaluated against the current state.
- Reset mid-sequence: all outputs return to reset values immediately, ps2_send_command drops asynchronously, and init restarts.

Test Plan:
- Normal init: after reset, bench returns command_was_sent, then 0xFA, then 0xAA -> one send of 0xFF observed, kbd_ready=1 within 2 cycles of the 0xAA strobe, kbd_error=0.
- Key decode: feed 0x1C; 0xF0,0x1C; 0xE0,0xF0,0x75 -> three key_valid pulses: (1C,ext0,rel0), (1C,0,1), (75,1,1); no pulses for the prefix bytes.
- LED update: led_req with led_value=3'b101 -> sends 0xED then 0x05, each completed with send_command dropped for ≥1 cycle; led_busy=1 from the accept cycle until the second 0xFA, then 0.
- Resend: answer 0xED with 0xFE twice, then 0xFA -> 0xED transmitted 3 times, then 0x05; kbd_error stays 0.
- Failure: with ACK_TIMEOUT=100 and RETRY_MAX=3, never ACK 0xFF -> exactly 4 sends of 0xFF, then kbd_error=1, kbd_ready=0, no further ps2_send_command.
- Reset mid-LED: assert reset while ps2_send_command=1 in LED_VAL -> send_command=0 and led_busy=0 immediately; after release a fresh 0xFF init starts.
